cim_seq_ctrl: RTL and testbench

- Command sequencer in front of the 16-core CiM macro.
- Accepts WRITE, READ, MAC and FENCE commands over a valid/ready interface.
- Drives the macro pins (ENCB/WEB/REB, banks, addresses, D, XIN) one operation per cycle and tracks in-flight READ/MAC ops through the macro's fixed pipeline latency.
- Captures Q into a credit-protected result FIFO, so results are never dropped under back-pressure.

---
 rtl/cim_ctrl_pkg.sv | 22 ++
 rtl/cim_res_fifo.sv | 56 +++++
 rtl/cim_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_cim_seq_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_ctrl_pkg.sv
// Shared types for the CiM command sequencer.
// Command opcodes, sequencer FSM states and the in-flight tag.
package cim_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_FENCE = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_MAC   = 2'd3
  } cmd_op_e;

  typedef enum logic {
    ST_RUN        = 1'b0,
    ST_FENCE_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic valid;
    logic is_mac;
  } tag_t;

endpackage

// File: rtl/cim_res_fifo.sv
// First-word-fall-through result FIFO.
// Ports: clk/rst, push+wdata, pop, rdata, full, empty, count.
module cim_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 23,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot a full push needs
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cim_seq_ctrl.sv
// Command sequencer for the 16-core CiM macro: registered pin drive,
// in-flight tag pipe, credit-protected result FIFO, FENCE handling.
module cim_seq_ctrl
  import cim_ctrl_pkg::*;
#(
  parameter int CORE_NUM         = 16,
  parameter int XIN_BIT_WIDTH    = 11,
  parameter int MEM_BIT_WIDTH    = 8,
  parameter int MEM_ADR_WIDTH    = 2,
  parameter int OUTPUT_BIT_WIDTH = 22,
  parameter int MACRO_LAT        = 8,
  parameter int RES_DEPTH        = 4,
  localparam int BW = $clog2(CORE_NUM),
  localparam int XW = CORE_NUM * XIN_BIT_WIDTH
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [BW-1:0]               cmd_bank,
  input  logic [MEM_ADR_WIDTH-1:0]    cmd_adr,
  input  logic [MEM_BIT_WIDTH-1:0]    cmd_wdata,
  input  logic [XW-1:0]               cmd_xin,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [OUTPUT_BIT_WIDTH-1:0] res_data,
  output logic                        res_is_mac,
  output logic                        busy,
  output logic                        ENCB,
  output logic                        WEB,
  output logic                        REB,
  output logic [BW-1:0]               BANKA,
  output logic [BW-1:0]               BANKB,
  output logic [MEM_ADR_WIDTH-1:0]    ADRA,
  output logic [MEM_ADR_WIDTH-1:0]    ADRB,
  output logic [MEM_BIT_WIDTH-1:0]    D,
  output logic [XW-1:0]               XIN,
  input  logic [OUTPUT_BIT_WIDTH-1:0] Q
);

  localparam int CNT_W = $clog2(RES_DEPTH + 1);

  state_e           state_q;
  state_e           state_d;
  logic             armed;
  cmd_op_e          op;
  logic             is_fence;
  logic             is_write;
  logic             is_read;
  logic             is_mac;
  logic             accept;
  logic             issue_rd;
  tag_t             issue_tag;
  tag_t             pipe [MACRO_LAT];
  logic             push;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_sum;
  logic             credit_ok;
  logic             fifo_full;
  logic             fifo_empty;

  assign op       = cmd_op_e'(cmd_op);
  assign is_fence = (op == OP_FENCE);
  assign is_write = (op == OP_WRITE);
  assign is_read  = (op == OP_READ);
  assign is_mac   = (op == OP_MAC);
  assign accept   = cmd_valid && cmd_ready;
  assign issue_rd = accept && (is_read || is_mac);
  assign push     = pipe[MACRO_LAT-1].valid;

  // every tag in flight owns a FIFO slot; pops only free it next cycle
  assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok  = !fifo_full
                   && (credit_sum < (CNT_W + 1)'(RES_DEPTH));

  assign busy = (state_q == ST_FENCE_WAIT)
             || (inflight != '0) || !fifo_empty;

  // keeps cmd_ready low until the first clock edge after reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) armed <= 1'b0;
    else     armed <= 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        cmd_ready = armed && credit_ok;
        if (cmd_valid && cmd_ready && is_fence)
          state_d = ST_FENCE_WAIT;
      end
      ST_FENCE_WAIT: begin
        if (inflight == '0 && fifo_empty)
          state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ENCB  <= 1'b1;
      WEB   <= 1'b1;
      REB   <= 1'b1;
      BANKA <= '0;
      BANKB <= '0;
      ADRA  <= '0;
      ADRB  <= '0;
      D     <= '0;
      XIN   <= '0;
    end else begin
      ENCB <= 1'b1;
      WEB  <= 1'b1;
      REB  <= 1'b1;
      if (accept) begin
        unique case (1'b1)
          is_write: begin
            WEB   <= 1'b0;
            BANKA <= cmd_bank;
            ADRA  <= cmd_adr;
            D     <= cmd_wdata;
          end
          is_read: begin
            REB   <= 1'b0;
            BANKB <= cmd_bank;
            ADRB  <= cmd_adr;
          end
          is_mac: begin
            ENCB <= 1'b0;
            ADRB <= cmd_adr;
            XIN  <= cmd_xin;
          end
          default: ;
        endcase
      end
    end
  end

  // issue_tag rides with the pins; the pipe then counts the macro latency
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      issue_tag <= '0;
      for (int i = 0; i < MACRO_LAT; i++)
        pipe[i] <= '0;
    end else begin
      issue_tag.valid  <= issue_rd;
      issue_tag.is_mac <= accept && is_mac;
      pipe[0] <= issue_tag;
      for (int i = 1; i < MACRO_LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inflight <= '0;
    end else begin
      unique case ({issue_rd, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  cim_res_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (OUTPUT_BIT_WIDTH + 1)
  ) u_res_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .wdata ({pipe[MACRO_LAT-1].is_mac, Q}),
    .pop   (res_ready),
    .rdata ({res_is_mac, res_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign res_valid = !fifo_empty;

endmodule

// File: tb/tb_cim_seq_ctrl.sv
// Scoreboard bench for cim_seq_ctrl with a behavioural macro model.
// Stimulus pushes expected results; a negedge monitor pops them.
module tb_cim_seq_ctrl;

  localparam int LAT = 8;
  localparam int XW  = 176;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [3:0]    cmd_bank;
  logic [1:0]    cmd_adr;
  logic [7:0]    cmd_wdata;
  logic [XW-1:0] cmd_xin;
  logic          res_valid;
  logic          res_ready;
  logic [21:0]   res_data;
  logic          res_is_mac;
  logic          busy;
  logic          ENCB, WEB, REB;
  logic [3:0]    BANKA, BANKB;
  logic [1:0]    ADRA, ADRB;
  logic [7:0]    D;
  logic [XW-1:0] XIN;
  logic [21:0]   Q;

  int tests = 0;
  int fails = 0;
  logic [22:0] exp_q [$];
  logic [22:0] mon_e;

  cim_seq_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_bank   (cmd_bank),
    .cmd_adr    (cmd_adr),
    .cmd_wdata  (cmd_wdata),
    .cmd_xin    (cmd_xin),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_is_mac (res_is_mac),
    .busy       (busy),
    .ENCB       (ENCB),
    .WEB        (WEB),
    .REB        (REB),
    .BANKA      (BANKA),
    .BANKB      (BANKB),
    .ADRA       (ADRA),
    .ADRB       (ADRB),
    .D          (D),
    .XIN        (XIN),
    .Q          (Q)
  );

  always #5 CLK = ~CLK;

  // macro model: READ returns the stored byte, MAC echoes XIN[21:0]
  logic [21:0] qd [LAT];
  logic [7:0]  wmem [16][4];
  logic [21:0] qin;

  always_comb begin
    qin = 22'h3FFFFF;
    if (!REB)       qin = {14'd0, wmem[BANKB][ADRB]};
    else if (!ENCB) qin = XIN[21:0];
  end

  always @(posedge CLK) begin
    qd[0] <= qin;
    for (int i = 1; i < LAT; i++) qd[i] <= qd[i-1];
    if (!WEB) wmem[BANKA][ADRA] <= D;
  end

  assign Q = qd[LAT-1];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_result: got %0h, want none",
                 res_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_data", {42'd0, res_data}, {42'd0, mon_e[21:0]});
        check("res_is_mac", {63'd0, res_is_mac}, {63'd0, mon_e[22]});
      end
    end
  end

  task automatic send(input logic [1:0]  op,
                      input logic [3:0]  bank,
                      input logic [1:0]  adr,
                      input logic [7:0]  wd,
                      input logic [21:0] x,
                      input logic [21:0] expd);
    bit ok;
    ok        = 1'b0;
    cmd_op    = op;
    cmd_bank  = bank;
    cmd_adr   = adr;
    cmd_wdata = wd;
    cmd_xin   = {154'd0, x};
    cmd_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok && (op == 2'd2 || op == 2'd3))
      exp_q.push_back({op == 2'd3, expd});
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no ready, want ready");
    end
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge CLK);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", {63'd0, ok}, 64'd1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int  acc;
    int  bad;
    bit  seen;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_bank  = '0;
    cmd_adr   = '0;
    cmd_wdata = '0;
    cmd_xin   = '0;
    res_ready = 1'b0;
    RST       = 1'b1;

    // reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_strobes", {61'd0, ENCB, WEB, REB}, 64'd7);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

    // WRITE pins for exactly one cycle
    @(posedge CLK);
    #1;
    send(2'd1, 4'd5, 2'd2, 8'hA5, 22'd0, 22'd0);
    @(negedge CLK);
    check("wr_web", {63'd0, WEB}, 64'd0);
    check("wr_banka", {60'd0, BANKA}, 64'd5);
    check("wr_adra", {62'd0, ADRA}, 64'd2);
    check("wr_d", {56'd0, D}, 64'hA5);
    check("wr_other", {62'd0, ENCB, REB}, 64'd3);
    @(negedge CLK);
    check("wr_web_release", {63'd0, WEB}, 64'd1);

    // READ latency: Q at t+9, res_valid at t+10
    @(posedge CLK);
    #1 res_ready = 1'b1;
    send(2'd2, 4'd5, 2'd2, 8'd0, 22'd0, 22'h0000A5);
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        check("rd_reb", {63'd0, REB}, 64'd0);
        check("rd_bankb", {60'd0, BANKB}, 64'd5);
        check("rd_adrb", {62'd0, ADRB}, 64'd2);
      end
      if (k == 9)
        check("rd_not_yet", {63'd0, res_valid}, 64'd0);
      if (k == 10)
        check("rd_valid_t10", {63'd0, res_valid}, 64'd1);
    end
    wait_idle(100);

    // credit: 4 of 6 back-to-back MACs accepted
    res_ready = 1'b0;
    acc       = 0;
    cmd_op    = 2'd3;
    cmd_adr   = 2'd1;
    cmd_xin   = {154'd0, 22'h100};
    cmd_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (cmd_ready) begin
        exp_q.push_back({1'b1, 22'h100 + 22'(acc)});
        acc++;
      end
      @(posedge CLK);
      #1 cmd_xin = {154'd0, 22'h100 + 22'(acc)};
    end
    check("mac_accepted", 64'(acc), 64'd4);
    @(negedge CLK);
    check("ready_low_credit", {63'd0, cmd_ready}, 64'd0);
    repeat (12) @(negedge CLK);
    check("fifo_holds", {63'd0, res_valid}, 64'd1);
    check("ready_low_full", {63'd0, cmd_ready}, 64'd0);
    @(posedge CLK);
    #1 res_ready = 1'b1;
    @(posedge CLK);
    #1 res_ready = 1'b0;
    @(negedge CLK);
    check("ready_after_pop", {63'd0, cmd_ready}, 64'd1);
    if (cmd_ready) begin
      exp_q.push_back({1'b1, 22'h100 + 22'(acc)});
      acc++;
    end
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    check("fifth_accepted", 64'(acc), 64'd5);
    res_ready = 1'b1;
    wait_idle(100);
    check("mac_drained", 64'(exp_q.size()), 64'd0);

    // FENCE waits for both MAC results to be popped
    res_ready = 1'b0;
    send(2'd3, 4'd0, 2'd3, 8'd0, 22'h2A5A5, 22'h2A5A5);
    @(negedge CLK);
    check("mac_encb", {63'd0, ENCB}, 64'd0);
    check("mac_adrb", {62'd0, ADRB}, 64'd3);
    check("mac_xin", {42'd0, XIN[21:0]}, 64'h2A5A5);
    @(posedge CLK);
    #1;
    send(2'd3, 4'd0, 2'd1, 8'd0, 22'h0F0F0, 22'h0F0F0);
    send(2'd0, 4'd0, 2'd0, 8'd0, 22'd0, 22'd0);
    @(negedge CLK);
    check("fence_no_strobe", {61'd0, ENCB, WEB, REB}, 64'd7);
    check("fence_ready_low", {63'd0, cmd_ready}, 64'd0);
    repeat (12) @(negedge CLK);
    check("fence_hold", {63'd0, cmd_ready}, 64'd0);
    check("fence_busy", {63'd0, busy}, 64'd1);
    @(posedge CLK);
    #1 res_ready = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (!res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("fence_drained", {63'd0, seen}, 64'd1);
    check("fence_ready_wait", {63'd0, cmd_ready}, 64'd0);
    @(negedge CLK);
    check("fence_release", {63'd0, cmd_ready}, 64'd1);

    // reset with READs in flight discards them
    @(posedge CLK);
    #1;
    send(2'd2, 4'd5, 2'd2, 8'd0, 22'd0, 22'h0000A5);
    send(2'd2, 4'd5, 2'd2, 8'd0, 22'd0, 22'h0000A5);
    send(2'd2, 4'd5, 2'd2, 8'd0, 22'd0, 22'h0000A5);
    RST = 1'b1;
    exp_q.delete();
    @(posedge CLK);
    #1 RST = 1'b0;
    bad = 0;
    for (int n = 0; n < 2 * LAT; n++) begin
      @(negedge CLK);
      if (res_valid || busy) bad++;
    end
    check("rst_flush", 64'(bad), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
